// File: rtl/plab5_mcore_mem_req_xbar_tdm_if.sv
`default_nettype none
// ============================================================================
// plab5_mcore_mem_req_xbar_tdm_if : request-side and bank-side bundle of the TDM request crossbar
// Rev 1.0
// ============================================================================
interface plab5_mcore_mem_req_xbar_tdm_if #(
  parameter int p_num_ports = 4,
  parameter int p_rq_nbits  = 77,
  parameter int p_sd_nbits  = 1,
  parameter int p_src_nbits = 2
);
  logic [p_num_ports*p_rq_nbits-1:0]  in_msg;
  logic [p_num_ports*p_sd_nbits-1:0]  in_sd;
  logic [p_num_ports-1:0]             in_val;
  logic [p_num_ports-1:0]             in_rdy;
  logic [p_num_ports*p_rq_nbits-1:0]  out_msg;
  logic [p_num_ports*p_sd_nbits-1:0]  out_sd;
  logic [p_num_ports*p_src_nbits-1:0] out_src;
  logic [p_num_ports-1:0]             out_val;
  logic [p_num_ports-1:0]             out_rdy;
  logic [p_sd_nbits-1:0]              cur_sd;
  logic                               epoch_dead;

  modport master (
    output in_msg, in_sd, in_val, out_rdy,
    input  in_rdy, out_msg, out_sd, out_src, out_val, cur_sd, epoch_dead
  );

  modport slave (
    input  in_msg, in_sd, in_val, out_rdy,
    output in_rdy, out_msg, out_sd, out_src, out_val, cur_sd, epoch_dead
  );
endinterface
`default_nettype wire

// File: rtl/plab5_mcore_mem_req_xbar_tdm.sv
`default_nettype none
// ============================================================================
// plab5_mcore_mem_req_xbar_tdm : N-port memory-request crossbar with per-input FIFOs,
// per-output round-robin arbitration and time-division security-domain epochs
// Rev 1.0
// ============================================================================
module plab5_mcore_mem_req_xbar_tdm #(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_num_ports        = 4,
  parameter int p_num_domains      = 2,
  parameter int p_fifo_depth       = 2,
  parameter int p_epoch_cycles     = 64,
  parameter int p_dead_cycles      = 4,
  parameter int p_bank_lsb         = p_mem_data_nbits + 6,
  parameter bit p_single_bank      = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  plab5_mcore_mem_req_xbar_tdm_if.slave        bus
);
  localparam int c_rq  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits
                         + $clog2(p_mem_data_nbits / 8) + p_mem_data_nbits;
  localparam int c_ns  = $clog2(p_num_ports);
  localparam int c_sdw = (p_num_domains > 1) ? $clog2(p_num_domains) : 1;
  localparam int c_aw  = $clog2(p_fifo_depth);
  localparam int c_cw  = c_aw + 1;
  localparam int c_ew  = (p_epoch_cycles > 1) ? $clog2(p_epoch_cycles) : 1;

  logic [c_rq-1:0]        fifo_msg_q [p_num_ports][p_fifo_depth];
  logic [c_rq-1:0]        fifo_msg_d [p_num_ports][p_fifo_depth];
  logic [c_sdw-1:0]       fifo_sd_q  [p_num_ports][p_fifo_depth];
  logic [c_sdw-1:0]       fifo_sd_d  [p_num_ports][p_fifo_depth];
  logic [c_aw-1:0]        wr_ptr_q [p_num_ports];
  logic [c_aw-1:0]        wr_ptr_d [p_num_ports];
  logic [c_aw-1:0]        rd_ptr_q [p_num_ports];
  logic [c_aw-1:0]        rd_ptr_d [p_num_ports];
  logic [c_cw-1:0]        cnt_q    [p_num_ports];
  logic [c_cw-1:0]        cnt_d    [p_num_ports];

  logic [p_num_ports-1:0] out_val_q, out_val_d;
  logic [c_rq-1:0]        out_msg_q [p_num_ports];
  logic [c_rq-1:0]        out_msg_d [p_num_ports];
  logic [c_sdw-1:0]       out_sd_q  [p_num_ports];
  logic [c_sdw-1:0]       out_sd_d  [p_num_ports];
  logic [c_ns-1:0]        out_src_q [p_num_ports];
  logic [c_ns-1:0]        out_src_d [p_num_ports];
  logic [c_ns-1:0]        rr_ptr_q  [p_num_ports];
  logic [c_ns-1:0]        rr_ptr_d  [p_num_ports];

  logic [c_ew-1:0]        ecnt_q, ecnt_d;
  logic [c_sdw-1:0]       cur_sd_q, cur_sd_d;
  logic                   epoch_dead;

  logic [c_rq-1:0]        head_msg [p_num_ports];
  logic [c_sdw-1:0]       head_sd  [p_num_ports];
  logic [c_ns-1:0]        dest     [p_num_ports];
  logic [c_ns-1:0]        win      [p_num_ports];
  logic [p_num_ports-1:0] head_val, in_rdy_w, enq, deq, grant, can_load;

  // Signed compare so an illegal dead window >= epoch length reads as permanently dead.
  assign epoch_dead = (int'(ecnt_q) >= (p_epoch_cycles - p_dead_cycles));

  always_comb begin
    for (int i = 0; i < p_num_ports; i++) begin
      head_msg[i] = fifo_msg_q[i][rd_ptr_q[i]];
      head_sd[i]  = fifo_sd_q[i][rd_ptr_q[i]];
      head_val[i] = (cnt_q[i] != '0);
      in_rdy_w[i] = (cnt_q[i] != c_cw'(p_fifo_depth));
      enq[i]      = bus.in_val[i] & in_rdy_w[i];
      dest[i]     = p_single_bank ? '0 : head_msg[i][p_bank_lsb +: c_ns];
    end
  end

  always_comb begin
    logic [c_ns-1:0] idx;
    idx      = '0;
    grant    = '0;
    deq      = '0;
    can_load = '0;
    for (int j = 0; j < p_num_ports; j++) begin
      win[j]      = rr_ptr_q[j];
      can_load[j] = !out_val_q[j] || bus.out_rdy[j];
      for (int k = 0; k < p_num_ports; k++) begin
        idx = rr_ptr_q[j] + c_ns'(k);
        if (!grant[j] && can_load[j] && !epoch_dead && head_val[idx] &&
            (dest[idx] == c_ns'(j)) && (head_sd[idx] == cur_sd_q)) begin
          grant[j] = 1'b1;
          win[j]   = idx;
        end
      end
      if (grant[j]) deq[win[j]] = 1'b1;
    end
  end

  always_comb begin
    fifo_msg_d = fifo_msg_q;
    fifo_sd_d  = fifo_sd_q;
    for (int i = 0; i < p_num_ports; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + c_aw'(enq[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + c_aw'(deq[i]);
      cnt_d[i]    = cnt_q[i] + c_cw'(enq[i]) - c_cw'(deq[i]);
      if (enq[i]) begin
        fifo_msg_d[i][wr_ptr_q[i]] = bus.in_msg[i*c_rq +: c_rq];
        fifo_sd_d[i][wr_ptr_q[i]]  = bus.in_sd[i*c_sdw +: c_sdw];
      end
    end
  end

  always_comb begin
    out_val_d = '0;
    for (int j = 0; j < p_num_ports; j++) begin
      out_msg_d[j] = out_msg_q[j];
      out_sd_d[j]  = out_sd_q[j];
      out_src_d[j] = out_src_q[j];
      rr_ptr_d[j]  = rr_ptr_q[j];
      if (grant[j]) begin
        out_val_d[j] = 1'b1;
        out_msg_d[j] = head_msg[win[j]];
        out_sd_d[j]  = head_sd[win[j]];
        out_src_d[j] = win[j];
        rr_ptr_d[j]  = win[j] + 1'b1;
      end else begin
        out_val_d[j] = out_val_q[j] && !bus.out_rdy[j];
      end
    end
  end

  always_comb begin
    ecnt_d   = ecnt_q + 1'b1;
    cur_sd_d = cur_sd_q;
    if (ecnt_q == c_ew'(p_epoch_cycles - 1)) begin
      ecnt_d   = '0;
      cur_sd_d = (cur_sd_q == c_sdw'(p_num_domains - 1)) ? '0 : cur_sd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_num_ports; i++) begin
        for (int e = 0; e < p_fifo_depth; e++) begin
          fifo_msg_q[i][e] <= '0;
          fifo_sd_q[i][e]  <= '0;
        end
        wr_ptr_q[i]  <= '0;
        rd_ptr_q[i]  <= '0;
        cnt_q[i]     <= '0;
        out_msg_q[i] <= '0;
        out_sd_q[i]  <= '0;
        out_src_q[i] <= '0;
        rr_ptr_q[i]  <= '0;
      end
      out_val_q <= '0;
      ecnt_q    <= '0;
      cur_sd_q  <= '0;
    end else begin
      fifo_msg_q <= fifo_msg_d;
      fifo_sd_q  <= fifo_sd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_msg_q  <= out_msg_d;
      out_sd_q   <= out_sd_d;
      out_src_q  <= out_src_d;
      rr_ptr_q   <= rr_ptr_d;
      out_val_q  <= out_val_d;
      ecnt_q     <= ecnt_d;
      cur_sd_q   <= cur_sd_d;
    end
  end

  for (genvar j = 0; j < p_num_ports; j++) begin : g_out
    assign bus.out_msg[j*c_rq +: c_rq]   = out_msg_q[j];
    assign bus.out_sd[j*c_sdw +: c_sdw]  = out_sd_q[j];
    assign bus.out_src[j*c_ns +: c_ns]   = out_src_q[j];
  end

  assign bus.out_val    = out_val_q;
  assign bus.in_rdy     = in_rdy_w;
  assign bus.cur_sd     = cur_sd_q;
  assign bus.epoch_dead = epoch_dead;

endmodule
`default_nettype wire

// File: tb/tb_plab5_mcore_mem_req_xbar_tdm.sv
`default_nettype none
// ============================================================================
// tb_plab5_mcore_mem_req_xbar_tdm : directed + scoreboarded bench for the TDM request crossbar
// Rev 1.0
// ============================================================================
module tb_plab5_mcore_mem_req_xbar_tdm;
  localparam int N    = 4;
  localparam int RQ   = 77;
  localparam int SDW  = 1;
  localparam int NS   = 2;
  localparam int EP   = 8;
  localparam int DC   = 2;
  localparam int BLSB = 38;
  localparam int SBD  = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_on = 1'b0;

  plab5_mcore_mem_req_xbar_tdm_if #(
    .p_num_ports(N), .p_rq_nbits(RQ), .p_sd_nbits(SDW), .p_src_nbits(NS)
  ) bus ();

  plab5_mcore_mem_req_xbar_tdm #(
    .p_num_ports(N), .p_num_domains(2), .p_fifo_depth(2),
    .p_epoch_cycles(EP), .p_dead_cycles(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  // Cycle model: cyc equals the crossbar's epoch-counter progression since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sd_of(input int c);
    return (c / EP) % 2;
  endfunction

  function automatic logic [RQ-1:0] mk(input logic [31:0] data, input int bank);
    logic [RQ-1:0] m;
    m = '0;
    m[31:0] = data;
    m[BLSB +: NS] = NS'(bank);
    return m;
  endfunction

  function automatic logic [RQ-1:0] omsg(input int j);
    return bus.out_msg[j*RQ +: RQ];
  endfunction

  function automatic logic [NS-1:0] osrc(input int j);
    return bus.out_src[j*NS +: NS];
  endfunction

  function automatic logic [SDW-1:0] osd(input int j);
    return bus.out_sd[j*SDW +: SDW];
  endfunction

  task automatic drive(input int p, input logic v, input logic [RQ-1:0] m, input logic s);
    bus.in_msg[p*RQ +: RQ] = m;
    bus.in_sd[p*SDW +: SDW] = s;
    bus.in_val[p] = v;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      check_eq("cur_sd", 128'(bus.cur_sd), 128'(sd_of(cyc)));
      check_eq("epoch_dead", 128'(bus.epoch_dead), 128'((cyc % EP) >= (EP - DC)));
    end
  end

  // Scoreboard indexed by src*N+dest; entries are {sd, msg}.
  logic [RQ+SDW-1:0] sb_mem [N*N][SBD];
  int                sb_wr  [N*N];
  int                sb_rd  [N*N];
  logic [N-1:0]      prev_val, prev_rdy;

  task automatic sb_step();
    int d;
    logic [RQ+SDW-1:0] e;
    for (int p = 0; p < N; p++) begin
      if (bus.in_val[p] && bus.in_rdy[p]) begin
        d = p * N + int'(bus.in_msg[p*RQ+BLSB +: NS]);
        sb_mem[d][sb_wr[d] % SBD] = {bus.in_sd[p*SDW +: SDW], bus.in_msg[p*RQ +: RQ]};
        sb_wr[d]++;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (bus.out_val[j]) begin
        if (!prev_val[j] || prev_rdy[j])
          check_eq("grant_sd", 128'(osd(j)), 128'(sd_of(cyc - 1)));
        if (bus.out_rdy[j]) begin
          d = int'(osrc(j)) * N + j;
          check_eq("sb_nonempty", 128'(sb_wr[d] != sb_rd[d]), 128'(1));
          if (sb_wr[d] != sb_rd[d]) begin
            e = sb_mem[d][sb_rd[d] % SBD];
            sb_rd[d]++;
            check_eq("sb_msg", 128'({osd(j), omsg(j)}), 128'(e));
          end
        end
      end
    end
    prev_val = bus.out_val;
    prev_rdy = bus.out_rdy;
  endtask

  initial begin
    int acc;
    int n_got;
    int outstanding;
    logic [RQ-1:0] got_msg [8];
    logic [RQ-1:0] m;
    int exp_src [5];
    logic [31:0] exp_dat [5];

    bus.in_msg  = '0;
    bus.in_sd   = '0;
    bus.in_val  = '0;
    bus.out_rdy = '1;
    for (int i = 0; i < N*N; i++) begin
      sb_wr[i] = 0;
      sb_rd[i] = 0;
    end

    repeat (3) @(negedge clk);
    check_eq("rst_out_val", 128'(bus.out_val), 128'(0));
    check_eq("rst_cur_sd", 128'(bus.cur_sd), 128'(0));
    check_eq("rst_dead", 128'(bus.epoch_dead), 128'(0));
    check_eq("rst_in_rdy", 128'(bus.in_rdy), 128'(4'hf));
    reset  = 1'b0;
    mon_on = 1'b1;

    // Single request: accepted cycle 1, visible cycle 3.
    to_cyc(1);
    drive(0, 1'b1, mk(32'h0000_00A0, 2), 1'b0);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    check_eq("single_early", 128'(bus.out_val), 128'(0));
    @(negedge clk);
    check_eq("single_val", 128'(bus.out_val), 128'(4'b0100));
    check_eq("single_msg", 128'(omsg(2)), 128'(mk(32'h0000_00A0, 2)));
    check_eq("single_src", 128'(osrc(2)), 128'(0));
    check_eq("single_sd", 128'(osd(2)), 128'(0));
    @(negedge clk);
    check_eq("single_drain", 128'(bus.out_val), 128'(0));

    // Contention on bank 1, then a 0-vs-2 race proving the pointer wrapped to 0.
    exp_src = '{0, 1, 3, 0, 2};
    exp_dat = '{32'hB0, 32'hB1, 32'hB3, 32'hC0, 32'hC2};
    to_cyc(16);
    drive(0, 1'b1, mk(32'hB0, 1), 1'b0);
    drive(1, 1'b1, mk(32'hB1, 1), 1'b0);
    drive(3, 1'b1, mk(32'hB3, 1), 1'b0);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    drive(3, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0, 1'b0, '0, 1'b0);
      drive(2, 1'b0, '0, 1'b0);
      if (k == 1) begin
        drive(0, 1'b1, mk(32'hC0, 1), 1'b0);
        drive(2, 1'b1, mk(32'hC2, 1), 1'b0);
      end
      check_eq("cont_val", 128'(bus.out_val), 128'(4'b0010));
      check_eq("cont_src", 128'(osrc(1)), 128'(exp_src[k]));
      check_eq("cont_msg", 128'(omsg(1)), 128'(mk(exp_dat[k], 1)));
    end
    @(negedge clk);
    check_eq("cont_done", 128'(bus.out_val), 128'(0));

    // Domain isolation: sd=1 request sent in a sd=0 epoch.
    to_cyc(33);
    drive(0, 1'b1, mk(32'hD0, 3), 1'b1);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    while (cyc < 41) begin
      check_eq("iso1_hold", 128'(bus.out_val), 128'(0));
      @(negedge clk);
    end
    check_eq("iso1_val", 128'(bus.out_val), 128'(4'b1000));
    check_eq("iso1_sd", 128'(osd(3)), 128'(1));
    check_eq("iso1_msg", 128'(omsg(3)), 128'(mk(32'hD0, 3)));

    // sd=0 request arriving in the dead window waits a full foreign epoch.
    to_cyc(54);
    drive(1, 1'b1, mk(32'hD1, 0), 1'b0);
    @(negedge clk);
    drive(1, 1'b0, '0, 1'b0);
    while (cyc < 65) begin
      check_eq("iso0_hold", 128'(bus.out_val), 128'(0));
      @(negedge clk);
    end
    check_eq("iso0_val", 128'(bus.out_val), 128'(4'b0001));
    check_eq("iso0_src", 128'(osrc(0)), 128'(1));
    check_eq("iso0_msg", 128'(omsg(0)), 128'(mk(32'hD1, 0)));

    // Backpressure: bank 0 stalled, port 0 streams.
    to_cyc(66);
    bus.out_rdy = 4'b1110;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, mk(32'hE000 + acc, 0), 1'b0);
      if (bus.in_rdy[0]) acc++;
      @(negedge clk);
    end
    drive(0, 1'b0, '0, 1'b0);
    check_eq("bp_accepted", 128'(acc), 128'(3));
    check_eq("bp_in_rdy", 128'(bus.in_rdy[0]), 128'(0));
    bus.out_rdy = 4'hf;
    n_got = 0;
    for (int k = 0; k < 19; k++) begin
      if (bus.out_val[0]) begin
        if (n_got < 8) got_msg[n_got] = omsg(0);
        n_got++;
      end
      @(negedge clk);
    end
    check_eq("bp_count", 128'(n_got), 128'(3));
    for (int k = 0; k < 3; k++)
      check_eq("bp_order", 128'(got_msg[k]), 128'(mk(32'hE000 + k, 0)));

    // Random traffic against the per-(src,dest) scoreboard.
    prev_val = bus.out_val;
    prev_rdy = bus.out_rdy;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        m = {$urandom(), $urandom(), $urandom()};
        m[BLSB +: NS] = NS'($urandom_range(0, N - 1));
        drive(p, ($urandom_range(0, 9) < 6), m, 1'($urandom_range(0, 1)));
      end
      for (int j = 0; j < N; j++) bus.out_rdy[j] = ($urandom_range(0, 3) != 0);
      sb_step();
      @(negedge clk);
    end
    bus.in_val  = '0;
    bus.out_rdy = '1;
    for (int c = 0; c < 80; c++) begin
      sb_step();
      @(negedge clk);
    end
    outstanding = 0;
    for (int i = 0; i < N*N; i++) outstanding += sb_wr[i] - sb_rd[i];
    check_eq("sb_drained", 128'(outstanding), 128'(0));
    check_eq("sb_idle", 128'(bus.out_val), 128'(0));

    // Asynchronous reset in the middle of traffic.
    bus.out_rdy = '0;
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < N; p++) drive(p, 1'b1, mk(32'hF0 + p, 2), 1'(sd_of(cyc)));
      @(negedge clk);
    end
    mon_on = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_out_val", 128'(bus.out_val), 128'(0));
    check_eq("arst_cur_sd", 128'(bus.cur_sd), 128'(0));
    check_eq("arst_dead", 128'(bus.epoch_dead), 128'(0));
    bus.in_val  = '0;
    bus.out_rdy = '1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("arst_in_rdy", 128'(bus.in_rdy), 128'(4'hf));
    check_eq("arst_out_idle", 128'(bus.out_val), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plab5_mcore_mem_req_xbar_tdm.md
# plab5_mcore_mem_req_xbar_tdm

Parametrised N-port memory-request crossbar with per-input buffering, per-output round-robin arbitration and built-in time-division security-domain scheduling. It replaces the fixed 4-port ring request path between processor/L1 ports and cache banks. It generates its own `cur_sd` epoch sequence with a dead (drain) window at each epoch end, and only forwards requests tagged with the currently active domain.

## Interface
- p_mem_opaque_nbits, 8, memory request opaque width (o)
- p_mem_addr_nbits, 32, address width (a)
- p_mem_data_nbits, 32, data width (d); rq = `VC_MEM_REQ_MSG_NBITS(o,a,d)`
- p_num_ports, 4, input and output port count N; power of two, ≥2; ns = $clog2(N)
- p_num_domains, 2, security domain count; sdw = max(1,$clog2(p_num_domains))
- p_fifo_depth, 2, per-input buffer entries; power of two, ≥2
- p_epoch_cycles, 64, cycles per domain epoch; must be > p_dead_cycles
- p_dead_cycles, 4, cycles at the end of each epoch during which no grants are issued
- p_bank_lsb, d+6, bit index of the bank-select field inside the request msg (address bits [5:4])
- p_single_bank, 0, 1 = every request is routed to output 0
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_msg  input  N*rq  request from input port i in slice [i*rq +: rq]
- in_sd  input  N*sdw  domain tag of the request on port i
- in_val  input  N  request valid per input port
- in_rdy  output  N  input port i can accept this cycle
- out_msg  output  N*rq  request to bank j in slice [j*rq +: rq]
- out_sd  output  N*sdw  domain tag of the request in out_msg slice j
- out_src  output  N*ns  input port that originated the request in slice j
- out_val  output  N  output j is valid
- out_rdy  input  N  bank j accepts this cycle
- cur_sd  output  sdw  active domain
- epoch_dead  output  1  high during the dead window

## Operation
- Epoch counter `ecnt` counts 0..p_epoch_cycles-1 and wraps. On each wrap `cur_sd` increments modulo p_num_domains. `epoch_dead` = (ecnt ≥ p_epoch_cycles-p_dead_cycles).
- Input i has a FIFO of p_fifo_depth entries, each holding {msg, sd}, with a registered occupancy count.
  - in_rdy[i] = !full, taken from registered state only; no enqueue bypass when full.
  - Enqueue on in_val[i] & in_rdy[i]. A simultaneous enqueue and dequeue leaves the count unchanged.
- Head destination: dest = p_single_bank ? 0 : head_msg[p_bank_lsb +: ns].
- Input i is a candidate for output j when all hold: head valid, dest==j, head_sd==cur_sd, !epoch_dead.
- Output j can load when its register is empty or is being drained this cycle (out_val[j] & out_rdy[j]).
- Arbitration per output j:
  - Round-robin among candidates, starting at rr_ptr[j].
  - On a grant to winner w: load the output register with {msg, sd, src=w}, dequeue the FIFO of w, and set rr_ptr[j] = (w+1) mod N.
  - With no grant, rr_ptr[j] holds.
- Each input has one head with one dest, so it wins at most one output per cycle. Outputs arbitrate independently.
- A request whose sd is not the active domain stays at the head and blocks that input until its epoch arrives. This is intentional: it gives no cross-domain timing interference.
- An output register already loaded is held across epoch boundaries until out_rdy. out_sd identifies its domain.
- Reset values:
  - All FIFOs empty; in_rdy all 1.
  - out_val all 0; out_msg, out_sd, out_src 0.
  - rr_ptr 0; ecnt 0; cur_sd 0; epoch_dead 0, or 1 if p_dead_cycles ≥ p_epoch_cycles (illegal).

## Timing
- Minimum latency is 2 cycles: a request accepted in cycle t is at the FIFO head in t+1, is granted in t+1, and gives out_val in t+2.
- Throughput is 1 request/cycle per output when there is no contention.
- The last grant of an epoch occurs at ecnt = p_epoch_cycles-p_dead_cycles-1. The first grant of the next epoch occurs at ecnt = 0 with the new cur_sd.
- out_msg, out_sd and out_src are stable while out_val & !out_rdy.
- Asynchronous reset mid-operation discards all buffered and output requests immediately.

## Test plan
- Reset: assert reset mid-traffic -> same cycle out_val=0, cur_sd=0, epoch_dead=0; after release in_rdy=all 1.
- Single request: in_val[0]=1 at cycle 1, sd=0, bank field=2 -> out_val[2]=1 at cycle 3 with identical msg, out_src=0, out_sd=0.
- Contention: ports 0, 1 and 3 send to bank 1 in the same cycle with out_rdy=1 -> delivered in src order 0,1,3 on consecutive cycles; rr_ptr[1] ends at 0.
- Domain isolation (p_epoch_cycles=8, p_dead_cycles=2): port 0 sends sd=1 at ecnt=1 of epoch 0 -> no out_val until out_val[dest] at ecnt=1 of the sd=1 epoch. A sd=0 request sent at ecnt=6 is held until the next sd=0 epoch.
- Backpressure: out_rdy[0]=0 and port 0 streams to bank 0 -> exactly p_fifo_depth+1 (3) requests accepted, then in_rdy[0]=0. Raising out_rdy drains in order with no loss or duplication.
- Random: all ports and domains with random out_rdy -> scoreboard matches per-(src,dest) order; no output ever carries sd≠cur_sd on its grant cycle.
